// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative divider.
package divider_pkg;

    typedef logic [63:0]  u64;
    typedef logic [127:0] u128;

    localparam int DIV_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider.sv
// Radix-2 restoring divider: WIDTH shift-subtract steps on magnitudes, sign fixup into c.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    div_state_t          state_r;
    div_state_t          state_nxt_s;
    logic [CW-1:0]       count_r;
    logic [WIDTH-1:0]    dividend_r;
    logic [WIDTH-1:0]    divisor_r;
    logic [WIDTH-1:0]    rem_r;
    logic                q_neg_r;
    logic                r_neg_r;
    logic [2*WIDTH-1:0]  c_r;

    logic [WIDTH-1:0]    a_mag_s;
    logic [WIDTH-1:0]    b_mag_s;
    logic [WIDTH:0]      shifted_s;
    logic [WIDTH:0]      diff_s;
    logic                qbit_s;
    logic [WIDTH-1:0]    rem_step_s;
    logic [WIDTH-1:0]    quot_step_s;
    logic [WIDTH-1:0]    quot_fix_s;
    logic [WIDTH-1:0]    rem_fix_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests are only accepted from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = valid ? DIVIDE : IDLE;
            DIVIDE:  state_nxt_s = (count_r == LAST_COUNT) ? FINISH : DIVIDE;
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: no stall whenever the machine will sit in IDLE next cycle.
    always_comb begin
        done = (state_nxt_s == IDLE);
    end

    // One restoring step plus the final sign fixup of the step result.
    always_comb begin
        a_mag_s     = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
        b_mag_s     = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
        shifted_s   = {rem_r, dividend_r[WIDTH-1]};
        diff_s      = shifted_s - {1'b0, divisor_r};
        if (!diff_s[WIDTH]) begin
            qbit_s     = 1'b1;
            rem_step_s = diff_s[WIDTH-1:0];
        end else begin
            qbit_s     = 1'b0;
            rem_step_s = shifted_s[WIDTH-1:0];
        end
        quot_step_s = {dividend_r[WIDTH-2:0], qbit_s};
        quot_fix_s  = q_neg_r ? ({WIDTH{1'b0}} - quot_step_s) : quot_step_s;
        rem_fix_s   = r_neg_r ? ({WIDTH{1'b0}} - rem_step_s) : rem_step_s;
    end

    // Datapath registers; the dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= {CW{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            c_r        <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid) begin
                        dividend_r <= a_mag_s;
                        divisor_r  <= b_mag_s;
                        rem_r      <= {WIDTH{1'b0}};
                        count_r    <= {CW{1'b0}};
                        q_neg_r    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != {WIDTH{1'b0}});
                        r_neg_r    <= is_signed & a[WIDTH-1];
                    end
                end
                DIVIDE: begin
                    dividend_r <= quot_step_s;
                    rem_r      <= rem_step_s;
                    count_r    <= count_r + CW'(1);
                    if (count_r == LAST_COUNT) begin
                        c_r <= {rem_fix_s, quot_fix_s};
                    end
                end
                FINISH: begin
                    c_r <= c_r;
                end
                default: begin
                    c_r <= c_r;
                end
            endcase
        end
    end

    assign c = c_r;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: expected results queued at request time, popped when done.
module tb_divider;
    import divider_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic valid;
    logic is_signed;
    u64   a;
    u64   b;
    logic done;
    u128  c;

    int   compared   = 0;
    int   mismatched = 0;
    u128  exp_q[$];

    divider #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .valid(valid), .is_signed(is_signed),
        .a(a), .b(b), .done(done), .c(c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input u128 obs, input u128 expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Independent RISC-V DIV/DIVU/REM/REMU reference.
    function automatic u128 model(input u64 x, input u64 y, input logic s);
        u64 q;
        u64 r;
        if (y == 64'd0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF;
            r = x;
        end else if (s && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = x;
            r = 64'd0;
        end else if (s) begin
            q = u64'($signed(x) / $signed(y));
            r = u64'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    // Called at a falling edge while the DUT is in IDLE.
    task automatic issue(input u64 x, input u64 y, input logic s, input u128 expv);
        a = x;
        b = y;
        is_signed = s;
        valid = 1'b1;
        exp_q.push_back(expv);
        #1;
        check("req_done_low", 128'(done), 128'd0);
    endtask

    task automatic wait_result(input string tag, input int drop_at, input logic hold);
        int  n = 0;
        u128 e;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n == drop_at) valid = 1'b0;
        end
        check({tag, "_latency"}, 128'(n), 128'd65);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check(tag, c, e);
        if (!hold) valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check(tag, 128'(done), 128'd1);
    endtask

    initial begin
        u64 ra;
        u64 rb;
        logic rs;

        reset = 1'b1;
        valid = 1'b0;
        is_signed = 1'b0;
        a = 64'd0;
        b = 64'd0;
        #1;
        check("reset_done", 128'(done), 128'd1);
        check("reset_c", c, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_check("idle_after_reset");

        issue(64'd100, 64'd7, 1'b0, {64'd2, 64'd14});
        wait_result("u100_7", 0, 1'b0);
        idle_check("idle_after_u100_7");

        // valid held through FINISH: the next IDLE cycle starts a fresh request
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD});
        wait_result("s_m7_2", 0, 1'b1);
        @(negedge clk);
        issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, {64'd1, 64'hFFFF_FFFF_FFFF_FFFD});
        wait_result("s_7_m2", 0, 1'b0);
        idle_check("idle_after_s_7_m2");

        issue(64'h1234, 64'd0, 1'b0, {64'h1234, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_result("u_div0", 10, 1'b0);
        idle_check("idle_after_u_div0");

        issue(64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, {64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_result("s_div0", 0, 1'b0);
        idle_check("idle_after_s_div0");

        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {64'd0, 64'h8000_0000_0000_0000});
        wait_result("s_overflow", 0, 1'b0);
        idle_check("idle_after_overflow");

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, {64'd1, 64'h7FFF_FFFF_FFFF_FFFF});
        wait_result("u_large", 0, 1'b0);
        idle_check("idle_after_u_large");

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom(), $urandom()};
            rb = (i < 2) ? u64'($urandom_range(1, 1000)) : {$urandom(), $urandom()};
            rs = 1'(i & 1);
            @(negedge clk);
            issue(ra, rb, rs, model(ra, rb, rs));
            wait_result("random", 0, 1'b0);
        end

        // back-to-back with one IDLE cycle; c must hold until the next latch
        @(negedge clk);
        issue(64'd1000, 64'd10, 1'b0, {64'd0, 64'd100});
        wait_result("b2b_first", 0, 1'b0);
        @(negedge clk);
        check("b2b_idle_done", 128'(done), 128'd1);
        check("b2b_hold_c", c, {64'd0, 64'd100});
        issue(64'd1000, 64'd3, 1'b0, {64'd1, 64'd333});
        check("b2b_hold_c_cycle0", c, {64'd0, 64'd100});
        wait_result("b2b_second", 0, 1'b0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        a = 64'd12345;
        b = 64'd17;
        is_signed = 1'b0;
        valid = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        check("async_reset_c", c, 128'd0);
        check("async_reset_done", 128'(done), 128'd1);
        @(negedge clk);
        reset = 1'b0;
        idle_check("idle_after_async_reset");
        issue(64'd9, 64'd3, 1'b0, {64'd0, 64'd3});
        wait_result("after_reset_9_3", 0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            idle_check("idle_constant");
        end

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
